mul_256: RTL and testbench
==========================

// Module: mul_256
// PURPOSE
// - Multi-cycle unsigned 256x256 -> 512-bit multiplier for the SM2 big-number datapath.
// - One 64x64 partial product per clock, accumulated into a 512-bit result register.
// - Started by a one-cycle start pulse; completion is flagged by a one-cycle done pulse.
// - Consumed by the modular-reduction / point-arithmetic controllers.
// PARAMETERS
// - W    256  operand width (fixed; other values unsupported)
// - LIMB 64   partial-product limb width; W/LIMB = 4 limbs per operand
// PORTS
// - clk    in   1    rising-edge clock
// - rst    in   1    asynchronous reset, active-high (one clock; async active-high reset)
// - a      in   256  multiplicand, unsigned; sampled only on the start cycle
// - b      in   256  multiplier, unsigned; sampled only on the start cycle
// - start  in   1    request pulse; a/b valid only while start=1 (may change next cycle)
// - c      out  512  product a*b; registered; valid when done=1; held until next accepted start
// - done   out  1    one-cycle pulse: c holds the final product
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, c=0, done=0, operand regs=0, counter=0.
// - States: IDLE, CALC, FIN.
// - IDLE + start=1:
//   - latch a->A, b->B; clear accumulator; cnt=0; go CALC.
//   - c is NOT cleared; it keeps the previous result until FIN.
// - CALC, per cycle, with i=cnt[3:2], j=cnt[1:0]:
//   - acc += (A[64i+:64] * B[64j+:64]) << (64*(i+j)).
//   - 128-bit product; 512-bit add, no overflow possible.
//   - cnt++; after cnt==15 go FIN.
// - FIN (one cycle): c<=acc; done<=1 for exactly this one cycle; go IDLE.
// - Latency:
//   - start sampled at edge E0; 16 CALC edges follow.
//   - c updates and done rises at edge E0+17; done falls at E0+18.
//   - Next start is accepted at E0+18.
// - start while in CALC or FIN: ignored; operands not resampled; no queueing.
// - start held high: re-triggers every time IDLE is reached (back-to-back runs).
// - a/b changing after the start cycle: no effect.
// - Reset mid-operation: aborts immediately; outputs return to reset values; no done pulse.
// - Arithmetic:
//   - unsigned throughout; result exact for all inputs.
//   - max*max = 2^512 - 2^257 + 1 (fits in 512 bits).
// STRUCTURE
// - Shared package (e.g. sm2_pkg):
//   - width constants W=256, W2=512, LIMB=64.
//   - state enum {IDLE, CALC, FIN}.
// - One sub-module mul64: combinational 64x64 -> 128 unsigned multiplier, instanced once.
// - Top holds A/B regs, 4-bit cnt, limb mux, shifter/adder into 512-bit acc, FSM, c/done regs.
// TESTING
// - Random a,b (8x32-bit $random each), 1-cycle start:
//   - done pulses exactly 17 clocks after the start edge;
//   - c == a*b (512-bit reference).
// - a=0, b=random -> c=0.
// - a=1, b=random -> c={256'b0,b}.
// - a=b=2^256-1 -> c = 2^512 - 2^257 + 1.
// - Drive a/b to 0 the cycle after start -> c is still the product of the sampled operands.
// - Second start pulse mid-CALC is ignored: single done, same c.
// - Reset asserted mid-CALC -> c=0, done=0, no done pulse.
// - Reset, then new start -> correct product for the new operands.

Source files
------------

// File: rtl/mul_256_pkg.sv
// Shared widths, FSM state type and partial-product placement helper for the
// 256x256 -> 512 multi-cycle multiplier.
package mul_256_pkg;

  localparam int W     = 256;
  localparam int W2    = 512;
  localparam int LIMB  = 64;
  localparam int NLIMB = W / LIMB;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  // Zero-extend a 128-bit partial product and move it to limb position pos (0..6).
  function automatic logic [W2-1:0] place_pp(input logic [2*LIMB-1:0] pp,
                                             input logic [2:0]        pos);
    logic [W2-1:0] wide;
    wide     = {{(W2-2*LIMB){1'b0}}, pp};
    place_pp = wide << (int'(pos) * LIMB);
  endfunction

endpackage

// File: rtl/mul_256_if.sv
// Operand/result bundle between a big-number controller (master) and mul_256 (slave).
interface mul_256_if;
  import mul_256_pkg::*;

  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          start;
  logic [W2-1:0] c;
  logic          done;

  modport master (output a, b, start, input c, done);
  modport slave  (input a, b, start, output c, done);

endinterface

// File: rtl/mul_256_mul64.sv
// Combinational unsigned 64x64 -> 128 limb multiplier, shared across all 16 steps.
module mul64
  import mul_256_pkg::*;
(
  input  logic [LIMB-1:0]   x,
  input  logic [LIMB-1:0]   y,
  output logic [2*LIMB-1:0] p
);

  assign p = {{LIMB{1'b0}}, x} * {{LIMB{1'b0}}, y};

endmodule

// File: rtl/mul_256.sv
// Multi-cycle 256x256 unsigned multiplier: one 64x64 partial product per clock,
// 16 accumulation steps, one-cycle done pulse when c is updated.
module mul_256
  import mul_256_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mul_256_if.slave   bus
);

  state_t state, next_state;

  logic [W-1:0]      opa, opb;
  logic [3:0]        cnt;
  logic [W2-1:0]     acc;
  logic [W2-1:0]     c_r;
  logic              done_r;

  logic              load, step, finish;
  logic [1:0]        ia, jb;
  logic [LIMB-1:0]   limb_a, limb_b;
  logic [2*LIMB-1:0] pp;
  logic [2:0]        pos;
  logic [W2-1:0]     pp_placed;

  // cnt walks the limb pairs row-major: upper bits pick the A limb, lower bits the B limb.
  assign ia     = cnt[3:2];
  assign jb     = cnt[1:0];
  assign limb_a = opa[int'(ia)*LIMB +: LIMB];
  assign limb_b = opb[int'(jb)*LIMB +: LIMB];
  assign pos    = {1'b0, ia} + {1'b0, jb};

  mul64 u_mul64 (
    .x (limb_a),
    .y (limb_b),
    .p (pp)
  );

  assign pp_placed = place_pp(pp, pos);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Start is only honoured from IDLE, so pulses during CALC/FIN are dropped.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == 4'd15) begin
          next_state = FIN;
        end
      end
      FIN: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // c keeps the previous product through a new run and only changes in FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      cnt    <= '0;
      acc    <= '0;
      c_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= finish;
      if (load) begin
        opa <= bus.a;
        opb <= bus.b;
        acc <= '0;
        cnt <= '0;
      end else if (step) begin
        acc <= acc + pp_placed;
        cnt <= cnt + 4'd1;
      end
      if (finish) begin
        c_r <= acc;
      end
    end
  end

  assign bus.c    = c_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_mul_256.sv
// Scoreboard bench for mul_256: stimulus pushes expected product and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_256;
  import mul_256_pkg::*;

  typedef struct {
    logic [W2-1:0] prod;
    int            doneCyc;
  } exp_t;

  localparam logic [W-1:0]  MAXV  = {W{1'b1}};
  localparam logic [W2-1:0] MAXSQ = {W2{1'b1}} - (512'd1 << 257) + 512'd2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   doneCount = 0;
  exp_t sb[$];

  mul_256_if bus ();

  mul_256 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W2-1:0] actual,
                             input logic [W2-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [W2-1:0] mulRef(input logic [W-1:0] x, input logic [W-1:0] y);
    mulRef = {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin : mon
      exp_t e;
      doneCount++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: actual=done at cycle %0d required=no done", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("product", bus.c, e.prod);
        checkOutput("done_latency", W2'(cyc), W2'(e.doneCyc));
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [W2-1:0] expected);
    exp_t e;
    @(negedge clk);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    e.prod    = expected;
    e.doneCyc = cyc + 18;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
  endtask

  task automatic waitIdle(input string name);
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    checkOutput(name, W2'(sb.size()), '0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic runVector(input string name, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W2-1:0] expected);
    applyStimulus(x, y, expected);
    waitIdle(name);
    checkOutput({name, "_held"}, bus.c, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0]  ra, rb, ra2, rb2;
    logic [W2-1:0] p1;
    int            c0, dc;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_c", bus.c, '0);
    checkOutput("reset_done", W2'(bus.done), '0);
    rst = 1'b0;

    ra = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    rb = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    ra2 = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
    rb2 = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};

    runVector("rand1", ra, rb, mulRef(ra, rb));
    runVector("zero_a", '0, rb, '0);
    runVector("one_a", 256'd1, rb, {{W{1'b0}}, rb});
    runVector("max_max", MAXV, MAXV, MAXSQ);
    runVector("limb0_sq", 256'hFFFFFFFFFFFFFFFF, 256'hFFFFFFFFFFFFFFFF,
              512'hFFFFFFFFFFFFFFFE0000000000000001);
    runVector("top_limbs", 256'd1 << 192, 256'd1 << 192, 512'd1 << 384);
    runVector("max_x2", MAXV, 256'd2, {255'b0, MAXV, 1'b0});
    runVector("diff_sq", (256'd1 << 64) + 256'd1, 256'hFFFFFFFFFFFFFFFF,
              {384'b0, {128{1'b1}}});
    runVector("mixed", (256'd2 << 192) + 256'd3, (256'd5 << 64) + 256'd7,
              (512'd10 << 256) + (512'd14 << 192) + (512'd15 << 64) + 512'd21);
    runVector("rand2", ra2, rb2, mulRef(ra2, rb2));

    // Second start mid-CALC must be ignored; c must still show the last result meanwhile.
    p1 = mulRef(ra, rb2);
    dc = doneCount;
    applyStimulus(ra, rb2, p1);
    repeat (4) @(negedge clk);
    checkOutput("c_kept_during_calc", bus.c, mulRef(ra2, rb2));
    bus.a     = MAXV;
    bus.b     = MAXV;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    waitIdle("ignore_mid_start");
    repeat (25) @(negedge clk);
    checkOutput("single_done", W2'(doneCount), W2'(dc + 1));
    checkOutput("ignore_mid_c", bus.c, p1);

    // Start held high: back-to-back runs, second one samples the operands present then.
    @(negedge clk);
    bus.a     = rb;
    bus.b     = ra2;
    bus.start = 1'b1;
    c0        = cyc;
    sb.push_back('{mulRef(rb, ra2), c0 + 18});
    sb.push_back('{mulRef(ra, rb), c0 + 36});
    @(negedge clk);
    bus.a = ra;
    bus.b = rb;
    while (cyc < c0 + 19) @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    waitIdle("back_to_back");

    // Reset mid-CALC aborts the run without a done pulse.
    applyStimulus(MAXV, rb, mulRef(MAXV, rb));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_c", bus.c, '0);
    checkOutput("abort_done", W2'(bus.done), '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    dc  = doneCount;
    repeat (25) @(negedge clk);
    checkOutput("abort_no_done", W2'(doneCount), W2'(dc));

    runVector("after_reset", ra2, MAXV, mulRef(ra2, MAXV));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
